// File: rtl/semaforo_pkg.sv
// Shared definitions for the intersection phase scheduler.
package semaforo_pkg;

  // One-hot light encodings for a road signal head.
  localparam logic [2:0] VERDE_L    = 3'b001;
  localparam logic [2:0] AMARELO_L  = 3'b010;
  localparam logic [2:0] VERMELHO_L = 3'b100;

  // Scheduler phases; the encoding is exported on the fase debug port.
  typedef enum logic [2:0] {
    A_VERDE   = 3'd0,
    A_AMARELO = 3'd1,
    VERM      = 3'd2,
    B_VERDE   = 3'd3,
    B_AMARELO = 3'd4,
    PEDESTRE  = 3'd5
  } estado_t;

  // Which road held the green last.
  typedef enum logic {
    ULT_A = 1'b0,
    ULT_B = 1'b1
  } via_t;

  // Default phase durations in cycles.
  localparam logic [7:0] T_VERDE_DEF    = 8'd1;
  localparam logic [7:0] T_AMARELO_DEF  = 8'd15;
  localparam logic [7:0] T_VERMELHO_DEF = 8'd10;

  // Duration register select codes (3 is ignored).
  localparam logic [1:0] SEL_VERDE    = 2'd0;
  localparam logic [1:0] SEL_AMARELO  = 2'd1;
  localparam logic [1:0] SEL_VERMELHO = 2'd2;

endpackage

// File: rtl/contador_fase.sv
// Loadable 8-bit down-counter timing one phase; a load of T yields T cycles.
module contador_fase #(
  parameter logic [7:0] RST_VAL = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] val,
  output logic       zero
);

  logic [7:0] cnt;

  // Load max(val,1)-1, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= (RST_VAL == 8'd0) ? 8'd0 : RST_VAL - 8'd1;
    end else if (load) begin
      cnt <= (val == 8'd0) ? 8'd0 : val - 8'd1;
    end else if (cnt != '0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/controle_cruzamento.sv
// Phase scheduler for a two-road intersection with a pedestrian crossing.
module controle_cruzamento
  import semaforo_pkg::*;
#(
  parameter logic [7:0] T_VERDE    = T_VERDE_DEF,
  parameter logic [7:0] T_AMARELO  = T_AMARELO_DEF,
  parameter logic [7:0] T_VERMELHO = T_VERMELHO_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       sb,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [7:0] cfg_val,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       P,
  output logic [2:0] fase
);

  estado_t    estado, prox;
  via_t       ultimo;
  logic       req_b, req_p;
  logic [7:0] t_verde, t_amarelo, t_vermelho;
  logic [7:0] dur_prox;
  logic       zero;

  // Every phase ends (or A_VERDE reloads) exactly when the counter reaches
  // zero, so the counter reload strobe is simply its own zero flag.
  contador_fase #(
    .RST_VAL(T_VERDE)
  ) u_contador (
    .clk (clk),
    .rst (rst),
    .load(zero),
    .val (dur_prox),
    .zero(zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= A_VERDE;
    else     estado <= prox;
  end

  // Next-state decision taken on counter expiry.
  always_comb begin
    prox = estado;
    if (zero) begin
      case (estado)
        A_VERDE:   if (req_b || req_p) prox = A_AMARELO;
        A_AMARELO: prox = VERM;
        B_VERDE:   prox = B_AMARELO;
        B_AMARELO: prox = VERM;
        VERM: begin
          if (req_p)                          prox = PEDESTRE;
          else if (ultimo == ULT_A && req_b)  prox = B_VERDE;
          else                                prox = A_VERDE;
        end
        PEDESTRE: begin
          if (ultimo == ULT_A && req_b) prox = B_VERDE;
          else                          prox = A_VERDE;
        end
        default: prox = A_VERDE;
      endcase
    end
  end

  // Duration of the phase about to be entered (current register contents).
  always_comb begin
    dur_prox = t_verde;
    case (prox)
      A_AMARELO, B_AMARELO: dur_prox = t_amarelo;
      VERM:                 dur_prox = t_vermelho;
      default:              dur_prox = t_verde;
    endcase
  end

  // Request latches; the entering edge clears and wins over a same-edge press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_p <= 1'b0;
      req_b <= 1'b0;
    end else begin
      if (prox == PEDESTRE && estado != PEDESTRE) req_p <= 1'b0;
      else if (bt && estado != PEDESTRE)          req_p <= 1'b1;
      if (prox == B_VERDE && estado != B_VERDE)   req_b <= 1'b0;
      else if (sb && estado != B_VERDE)           req_b <= 1'b1;
    end
  end

  // Remember the road that received the green most recently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ultimo <= ULT_A;
    end else if (zero) begin
      if (prox == A_VERDE)      ultimo <= ULT_A;
      else if (prox == B_VERDE) ultimo <= ULT_B;
    end
  end

  // Run-time duration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_verde    <= T_VERDE;
      t_amarelo  <= T_AMARELO;
      t_vermelho <= T_VERMELHO;
    end else if (cfg_we) begin
      case (cfg_sel)
        SEL_VERDE:    t_verde    <= cfg_val;
        SEL_AMARELO:  t_amarelo  <= cfg_val;
        SEL_VERMELHO: t_vermelho <= cfg_val;
        default: ;
      endcase
    end
  end

  // Moore light decode from the state register.
  always_comb begin
    A = VERMELHO_L;
    B = VERMELHO_L;
    P = 1'b0;
    case (estado)
      A_VERDE:   A = VERDE_L;
      A_AMARELO: A = AMARELO_L;
      B_VERDE:   B = VERDE_L;
      B_AMARELO: B = AMARELO_L;
      PEDESTRE:  P = 1'b1;
      default: ;
    endcase
  end

  assign fase = estado;

endmodule

// File: tb/tb_controle_cruzamento.sv
// Self-checking bench for controle_cruzamento against a phase-timeline model.
module tb_controle_cruzamento;
  import semaforo_pkg::*;

  logic       clk = 1'b0;
  logic       rst, bt, sb, cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_val;
  logic [2:0] A, B, fase;
  logic       P;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  controle_cruzamento #(
    .T_VERDE   (8'd1),
    .T_AMARELO (8'd15),
    .T_VERMELHO(8'd10)
  ) dut (
    .clk(clk), .rst(rst), .bt(bt), .sb(sb),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_val(cfg_val),
    .A(A), .B(B), .P(P), .fase(fase)
  );

  always #5 clk = ~clk;

  // Both roads green at once is unrecoverable.
  always @(negedge clk) begin
    if (!rst && A == 3'b001 && B == 3'b001) begin
      $display("FAIL safety: A=%b B=%b both green", A, B);
      $fatal(1, "conflicting greens");
    end
  end

  // Reference model: phase, cycles spent in it, its length fixed at entry.
  estado_t     m_fase;
  int unsigned m_gasto, m_dur, m_ped;
  bit          m_rb, m_rp, m_ult_b;
  int unsigned m_t[3];

  task automatic verificar(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned duracao(estado_t s);
    int unsigned t;
    case (s)
      A_AMARELO, B_AMARELO: t = m_t[1];
      VERM:                 t = m_t[2];
      default:              t = m_t[0];
    endcase
    return (t == 0) ? 1 : t;
  endfunction

  // {A, B, P} expected while in a phase.
  function automatic logic [6:0] luzes(estado_t s);
    case (s)
      A_VERDE:   return 7'b001_100_0;
      A_AMARELO: return 7'b010_100_0;
      VERM:      return 7'b100_100_0;
      B_VERDE:   return 7'b100_001_0;
      B_AMARELO: return 7'b100_010_0;
      default:   return 7'b100_100_1;
    endcase
  endfunction

  task automatic model_reset();
    m_t[0] = 1; m_t[1] = 15; m_t[2] = 10;
    m_fase = A_VERDE; m_gasto = 0; m_dur = 1;
    m_rb = 0; m_rp = 0; m_ult_b = 0;
  endtask

  task automatic model_step();
    estado_t nxt;
    bit      fim;
    nxt = m_fase;
    fim = (m_gasto + 1 >= m_dur);
    if (fim) begin
      case (m_fase)
        A_VERDE:   nxt = (m_rb || m_rp) ? A_AMARELO : A_VERDE;
        A_AMARELO: nxt = VERM;
        B_VERDE:   nxt = B_AMARELO;
        B_AMARELO: nxt = VERM;
        VERM:      nxt = m_rp ? PEDESTRE : ((!m_ult_b && m_rb) ? B_VERDE : A_VERDE);
        default:   nxt = (!m_ult_b && m_rb) ? B_VERDE : A_VERDE;
      endcase
    end
    if (fim && nxt == PEDESTRE) begin m_rp = 0; m_ped++; end
    else if (bt && m_fase != PEDESTRE) m_rp = 1;
    if (fim && nxt == B_VERDE && m_fase != B_VERDE) m_rb = 0;
    else if (sb && m_fase != B_VERDE) m_rb = 1;
    if (fim) begin
      m_dur = duracao(nxt);
      m_gasto = 0;
      if (nxt == A_VERDE) m_ult_b = 0;
      if (nxt == B_VERDE) m_ult_b = 1;
    end else begin
      m_gasto++;
    end
    m_fase = nxt;
    if (cfg_we && cfg_sel != 2'd3) m_t[cfg_sel] = cfg_val;
  endtask

  task automatic comparar();
    logic [6:0] e;
    e = luzes(m_fase);
    verificar("A", A, e[6:4]);
    verificar("B", B, e[3:1]);
    verificar("P", P, e[0]);
    verificar("fase", fase, m_fase);
    verificar("p_safe", P && (A == 3'b001 || B == 3'b001), 0);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic ciclo();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    comparar();
  endtask

  // Length of the next occurrence of a phase; optional write on its first cycle.
  task automatic medir(input estado_t alvo, input logic wr, input logic [1:0] sel,
                       input logic [7:0] val, output int unsigned len);
    int unsigned guarda;
    guarda = 0;
    len = 0;
    while (fase != alvo && guarda < 400) begin ciclo(); guarda++; end
    if (fase != alvo) begin
      verificar("timeout_wait", fase, alvo);
      return;
    end
    len = 1;
    cfg_we = wr; cfg_sel = sel; cfg_val = val;
    for (int i = 0; i < 400; i++) begin
      ciclo();
      cfg_we = 1'b0;
      if (fase == alvo) len++;
      else break;
    end
  endtask

  task automatic reiniciar();
    rst = 1'b1;
    model_reset();
    ciclo();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned len, n_ped_dut;
    logic        p_ant;
    rst = 1'b1; bt = 1'b0; sb = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_val = '0;
    model_reset();
    #2;
    verificar("rst_A", A, 3'b001);
    verificar("rst_B", B, 3'b100);
    verificar("rst_P", P, 1'b0);
    verificar("rst_fase", fase, A_VERDE);
    ciclo();
    rst = 1'b0;

    // Idle: A stays green.
    for (int i = 0; i < 50; i++) ciclo();

    // Car on B with default durations.
    reiniciar();
    ciclo(); ciclo();
    sb = 1'b1; ciclo(); sb = 1'b0;
    medir(A_AMARELO, 1'b0, 2'd0, 8'd0, len); verificar("len_a_am", len, 15);
    medir(VERM,      1'b0, 2'd0, 8'd0, len); verificar("len_verm1", len, 10);
    verificar("after_verm1", fase, B_VERDE);
    medir(B_VERDE,   1'b0, 2'd0, 8'd0, len); verificar("len_b_vd", len, 1);
    medir(B_AMARELO, 1'b0, 2'd0, 8'd0, len); verificar("len_b_am", len, 15);
    medir(VERM,      1'b0, 2'd0, 8'd0, len); verificar("len_verm2", len, 10);
    verificar("after_verm2", fase, A_VERDE);

    // Pedestrian and car together: walk then B, not A.
    reiniciar();
    bt = 1'b1; sb = 1'b1; ciclo(); bt = 1'b0; sb = 1'b0;
    medir(PEDESTRE, 1'b0, 2'd0, 8'd0, len); verificar("len_ped", len, 1);
    verificar("after_ped", fase, B_VERDE);

    // Duration writes apply from the next phase entry; zero acts as one.
    reiniciar();
    sb = 1'b1; ciclo(); sb = 1'b0;
    medir(A_AMARELO, 1'b1, 2'd1, 8'd3, len); verificar("len_am_cur", len, 15);
    medir(B_AMARELO, 1'b1, 2'd2, 8'd0, len); verificar("len_am_new", len, 3);
    medir(VERM,      1'b0, 2'd0, 8'd0, len); verificar("len_verm_zero", len, 1);

    // Asynchronous reset in the middle of B yellow.
    reiniciar();
    sb = 1'b1; ciclo(); sb = 1'b0;
    for (int i = 0; i < 200 && fase != B_AMARELO; i++) ciclo();
    ciclo(); ciclo();
    bt = 1'b1; sb = 1'b1; ciclo(); bt = 1'b0; sb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    verificar("arst_A", A, 3'b001);
    verificar("arst_B", B, 3'b100);
    verificar("arst_fase", fase, A_VERDE);
    ciclo();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) ciclo();
    verificar("arst_reqs_clear", fase, A_VERDE);

    // Button held: walk served once per sequence round.
    reiniciar();
    m_ped = 0; n_ped_dut = 0; p_ant = 1'b0;
    bt = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ciclo();
      if (P && !p_ant) n_ped_dut++;
      p_ant = P;
    end
    bt = 1'b0;
    verificar("ped_rounds", n_ped_dut, m_ped);

    // Randomized traffic, presses and duration writes.
    reiniciar();
    for (int i = 0; i < 4000; i++) begin
      bt = ($urandom_range(0, 19) == 0);
      sb = ($urandom_range(0, 9) == 0);
      cfg_we = ($urandom_range(0, 49) == 0);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_val = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        ciclo();
        rst = 1'b0;
      end else begin
        ciclo();
      end
    end
    bt = 1'b0; sb = 1'b0; cfg_we = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/controle_cruzamento.md
# controle_cruzamento

Phase scheduler for a two-road intersection with a pedestrian crossing. It sequences the A and B traffic lights and a pedestrian walk signal, and shares the crossing between main road A, side road B (car sensor) and pedestrians (button). Phase durations are run-time configurable. The block sits above the light outputs and is the sole owner of their sequencing.

## Interface
Parameters:
- T_VERDE, 8'd1: reset value of the green-phase duration in cycles; also the pedestrian walk duration.
- T_AMARELO, 8'd15: reset value of the yellow-phase duration.
- T_VERMELHO, 8'd10: reset value of the all-red clearance duration.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bt  in  1  pedestrian button. Level sampled each cycle.
- sb  in  1  car sensor on road B. Level sampled each cycle.
- cfg_we  in  1  duration write strobe.
- cfg_sel  in  2  register select: 0 = verde, 1 = amarelo, 2 = vermelho. 3 = ignored.
- cfg_val  in  8  duration value.
- A  out  3  road A light: 3'b001 verde, 3'b010 amarelo, 3'b100 vermelho.
- B  out  3  road B light, same encoding.
- P  out  1  pedestrian walk.
- fase  out  3  current state encoding, for debug.

## Operation
- States and outputs (A/B/P):
  - A_VERDE: 001/100/0.
  - A_AMARELO: 010/100/0.
  - VERM: 100/100/0.
  - B_VERDE: 100/001/0.
  - B_AMARELO: 100/010/0.
  - PEDESTRE: 100/100/1.
- Transitions, taken when the phase counter expires:
  - A_VERDE → A_AMARELO if req_b or req_p. Otherwise the block stays in A_VERDE and the counter reloads.
  - A_AMARELO → VERM.
  - B_VERDE → B_AMARELO. There is no extension on B.
  - B_AMARELO → VERM.
  - VERM → PEDESTRE if req_p. Else → B_VERDE if ultimo==A and req_b. Else → A_VERDE.
  - PEDESTRE → B_VERDE if ultimo==A and req_b. Else → A_VERDE.
- ultimo: 1-bit register recording which road was green last. It is set to A on entry to A_VERDE and to B on entry to B_VERDE.
- req_p:
  - Set by bt=1 in any state except PEDESTRE.
  - Cleared on the edge that enters PEDESTRE. A bt sampled on that same edge is dropped.
- req_b:
  - Set by sb=1 in any state except B_VERDE.
  - Cleared on the edge that enters B_VERDE. A sb sampled on that same edge is dropped.
- Durations:
  - Three 8-bit registers, written on cfg_we at the clock edge.
  - A write takes effect at the next phase entry; the running phase is unaffected.
  - A value of 0 is treated as 1.
- A green and B green are never active in the same cycle; any such cycle is a fatal bench assertion.

## Timing
- Moore outputs, decoded from the state register only. Outputs change on the clock edge that changes state.
- Phase counter:
  - On state entry (or A_VERDE reload) it loads max(T,1)−1 for the phase's duration T.
  - It decrements every cycle.
  - The transition fires on the edge where counter==0 and the exit condition holds.
  - Each phase therefore lasts exactly T cycles.
- Request latency: a request sampled in cycle n is visible to the transition decision at edge n+1.
- Reset (asynchronous, effective immediately):
  - State A_VERDE, counter = T_VERDE−1, A=001, B=100, P=0, fase=A_VERDE.
  - req_b=0, req_p=0, ultimo=A.
  - Duration registers return to their parameter values.
  - Reset mid-phase aborts that phase with no clearance.
- Counter width is 8 bits. Durations of up to 255 cycles are supported with no wrap.

## Structure
- Shared package semaforo_pkg holds:
  - light encodings VERDE_L, AMARELO_L, VERMELHO_L;
  - the state enum;
  - default durations 1/15/10;
  - cfg_sel codes.
- Sub-module contador_fase: 8-bit loadable down-counter.
  - Inputs clk, rst, load, val[7:0].
  - Outputs zero.
  - It applies the 0→1 clamp internally.
- All remaining logic (FSM, request latches, config registers) lives in controle_cruzamento.

## Test plan
- Reset held, then released, with bt=sb=0 for 50 cycles → A=001, B=100, P=0 throughout.
- sb pulsed 1 cycle at t=3, with defaults → the sequence below, then A_VERDE.
  - A_AMARELO for 15 cycles.
  - VERM for 10.
  - B_VERDE for 1.
  - B_AMARELO for 15.
  - VERM for 10.
- bt and sb both pulsed in the same cycle → after VERM the block enters PEDESTRE with P=1 for 1 cycle, then goes to B_VERDE (not A_VERDE).
- Write cfg_sel=1 with cfg_val=8'd3 during A_AMARELO, then request again → the current yellow still lasts 15 cycles and the next yellow lasts 3. Writing cfg_val=0 to vermelho gives a 1-cycle VERM.
- Async reset asserted mid-B_AMARELO, between clock edges → A=001 and B=100 immediately, requests cleared.
- bt held high continuously → PEDESTRE is served once per cycle of the sequence. P is never 1 while A or B is green, and A and B are never green together.
